// File: rtl/mem_readout_pkg.sv
// rtl/mem_readout_pkg.sv - shared types and constants for the memory readout scheduler
//
// Purpose: select-code width/encoding, the scheduler state type and the
//          index-to-select mapping used by mem_readout_sched.
// Contents:
//   NMEM_MAX  - largest memory count the 4-bit select code can address
//   SEL_W     - mux select width
//   SEL_IDLE  - select code driven when no memory is being read
//   state_t   - IDLE / PICK / READ / DONE
//   sel_code  - memory index -> mux select (index + 1)
package mem_readout_pkg;

  localparam int NMEM_MAX = 14;
  localparam int SEL_W    = 4;

  localparam logic [SEL_W-1:0] SEL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  // Select code 0 is unused by the mux; memory i maps to i+1.
  function automatic logic [SEL_W-1:0] sel_code(input logic [SEL_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/mem_readout_sched_prio_pick.sv
// rtl/mem_readout_sched_prio_pick.sv - lowest-index-first priority encoder
//
// Purpose: combinational encoder returning the lowest set bit of a mask.
// Ports:
//   i_mask [N-1:0]     - request mask, bit i is memory i
//   o_idx  [SEL_W-1:0] - index of the lowest set bit (0 when none set)
//   o_any              - at least one bit of i_mask is set
module prio_pick
  import mem_readout_pkg::*;
#(
  parameter int N = 12
) (
  input  logic [N-1:0]     i_mask,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = SEL_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_readout_sched.sv
// rtl/mem_readout_sched.sv - readout scheduler walking non-empty memory blocks into the stream mux
//
// Purpose: on start, snapshot which memories hold data and their entry
//          counts, then stream one read address per accepted beat for each
//          non-empty memory (memory 0 first), driving the mux select.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   start      - event start, honoured only in IDLE
//   flush      - synchronous abort back to IDLE, no done
//   has_dat    - per-memory non-empty flag
//   nent       - per-memory entry counts, memory i at [i*ADDR_W +: ADDR_W]
//   out_ready  - downstream accepts the current beat
//   out_valid  - sel/rd_addr describe a read beat
//   sel        - mux select (i+1 for memory i, 4'b1111 otherwise)
//   rd_addr    - entry address within the selected memory
//   busy       - scheduler not in IDLE
//   done       - one-cycle pulse when the event has drained
//   none       - pulses with done when the event had no pending memory
module mem_readout_sched
  import mem_readout_pkg::*;
#(
  parameter int NMEM   = 12,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   flush,
  input  logic [NMEM-1:0]        has_dat,
  input  logic [NMEM*ADDR_W-1:0] nent,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       sel,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   none
);

  state_t                   r_state;
  logic [NMEM-1:0]          r_pend;
  logic [NMEM*ADDR_W-1:0]   r_nent;
  logic [SEL_W-1:0]         r_cur;
  logic                     r_any_sent;

  logic                     r_out_valid;
  logic [SEL_W-1:0]         r_sel;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_none;

  logic [NMEM-1:0]          w_snap_pend;
  logic [ADDR_W-1:0]        w_cur_cnt;
  logic [SEL_W-1:0]         w_pick_idx;
  logic                     w_pick_any;
  logic [NMEM-1:0]          w_pend_clr;
  logic                     w_xfer;
  logic                     w_last;

  // A memory only counts as pending when its flag and its count agree.
  always_comb begin
    w_snap_pend = '0;
    for (int i = 0; i < NMEM; i++) begin
      w_snap_pend[i] = has_dat[i] && (nent[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Entry count of the memory currently being read, from the snapshot.
  always_comb begin
    w_cur_cnt = '0;
    for (int i = 0; i < NMEM; i++) begin
      if (r_cur == SEL_W'(i)) begin
        w_cur_cnt = r_nent[i*ADDR_W +: ADDR_W];
      end
    end
  end

  prio_pick #(
    .N(NMEM)
  ) u_prio_pick (
    .i_mask (r_pend),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_pend_clr = r_pend & ~(NMEM'(1) << w_pick_idx);
  assign w_xfer     = r_out_valid && out_ready;
  assign w_last     = (r_rd_addr == (w_cur_cnt - ADDR_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_nent      <= '0;
      r_cur       <= '0;
      r_any_sent  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sel       <= SEL_IDLE;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_none      <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_sel       <= SEL_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_none      <= 1'b0;
    end else begin
      // done/none are single-cycle pulses unless re-armed below.
      r_done <= 1'b0;
      r_none <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_pend     <= w_snap_pend;
            r_nent     <= nent;
            r_any_sent <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= PICK;
          end
        end
        PICK: begin
          if (!w_pick_any) begin
            r_done  <= 1'b1;
            r_none  <= !r_any_sent;
            r_state <= DONE;
          end else begin
            r_cur       <= w_pick_idx;
            r_rd_addr   <= '0;
            r_pend      <= w_pend_clr;
            r_any_sent  <= 1'b1;
            r_out_valid <= 1'b1;
            r_sel       <= sel_code(w_pick_idx);
            r_state     <= READ;
          end
        end
        READ: begin
          if (w_xfer) begin
            if (w_last) begin
              // Memory drained: one bubble cycle in PICK before the next one.
              r_out_valid <= 1'b0;
              r_sel       <= SEL_IDLE;
              r_state     <= PICK;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_sel       <= SEL_IDLE;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sel       = r_sel;
  assign rd_addr   = r_rd_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign none      = r_none;

endmodule

// File: tb/tb_mem_readout_sched.sv
// tb/tb_mem_readout_sched.sv - directed self-checking bench for mem_readout_sched
module tb_mem_readout_sched;

  localparam int NMEM   = 12;
  localparam int ADDR_W = 6;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic                   flush;
  logic [NMEM-1:0]        has_dat;
  logic [NMEM*ADDR_W-1:0] nent;
  logic                   out_ready;
  logic                   out_valid;
  logic [3:0]             sel;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   busy;
  logic                   done;
  logic                   none;

  int total = 0;
  int bad   = 0;

  mem_readout_sched #(
    .NMEM   (NMEM),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .flush     (flush),
    .has_dat   (has_dat),
    .nent      (nent),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .none      (none)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle of the beat stream; sel/rd_addr only matter when valid.
  task automatic exp_cyc(input string tag, input logic v, input logic [3:0] s,
                         input logic [5:0] a, input logic d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".done"},  32'(done),      32'(d));
    if (v) begin
      chk({tag, ".sel"},  32'(sel),     32'(s));
      chk({tag, ".addr"}, 32'(rd_addr), 32'(a));
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".sel"},   32'(sel),       32'hF);
    chk({tag, ".addr"},  32'(rd_addr),   32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".done"},  32'(done),      32'd0);
    chk({tag, ".none"},  32'(none),      32'd0);
  endtask

  task automatic set_cnt(input int idx, input logic [5:0] val);
    nent[idx*ADDR_W +: ADDR_W] = val;
  endtask

  task automatic setup_skip();
    has_dat = 12'b0010_0000_0101;
    nent    = '0;
    set_cnt(0, 6'd2);
    set_cnt(2, 6'd1);
    set_cnt(9, 6'd3);
  endtask

  task automatic setup_mismatch();
    has_dat = 12'b0000_0110_0000;
    nent    = '0;
    set_cnt(5, 6'd0);
    set_cnt(6, 6'd1);
  endtask

  // Skip-empties event; poke=1 pulses start twice while busy.
  task automatic run_skip(input string tag, input bit poke);
    setup_skip();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    exp_cyc({tag, ".pick0"}, 1'b0, 4'h0, 6'd0, 1'b0);
    step(); exp_cyc({tag, ".b0"}, 1'b1, 4'd1, 6'd0, 1'b0);
    step(); exp_cyc({tag, ".b1"}, 1'b1, 4'd1, 6'd1, 1'b0);
    if (poke) start = 1'b1;
    step(); exp_cyc({tag, ".bub1"}, 1'b0, 4'h0, 6'd0, 1'b0);
    start = 1'b0;
    step(); exp_cyc({tag, ".b2"}, 1'b1, 4'd3, 6'd0, 1'b0);
    if (poke) start = 1'b1;
    step(); exp_cyc({tag, ".bub2"}, 1'b0, 4'h0, 6'd0, 1'b0);
    start = 1'b0;
    step(); exp_cyc({tag, ".b3"}, 1'b1, 4'd10, 6'd0, 1'b0);
    step(); exp_cyc({tag, ".b4"}, 1'b1, 4'd10, 6'd1, 1'b0);
    step(); exp_cyc({tag, ".b5"}, 1'b1, 4'd10, 6'd2, 1'b0);
    step(); exp_cyc({tag, ".bub3"}, 1'b0, 4'h0, 6'd0, 1'b0);
    step();
    exp_cyc({tag, ".fin"}, 1'b0, 4'h0, 6'd0, 1'b1);
    chk({tag, ".none"}, 32'(none), 32'd0);
    chk({tag, ".busy_done"}, 32'(busy), 32'd1);
    step();
    chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
    chk({tag, ".done_clr"},  32'(done), 32'd0);
  endtask

  task automatic run_mismatch(input string tag);
    setup_mismatch();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_cyc({tag, ".pick"}, 1'b0, 4'h0, 6'd0, 1'b0);
    step(); exp_cyc({tag, ".b0"}, 1'b1, 4'd7, 6'd0, 1'b0);
    step(); exp_cyc({tag, ".bub"}, 1'b0, 4'h0, 6'd0, 1'b0);
    step();
    exp_cyc({tag, ".fin"}, 1'b0, 4'h0, 6'd0, 1'b1);
    chk({tag, ".none"}, 32'(none), 32'd0);
    step();
    chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic run_empty(input string tag);
    has_dat = '0;
    nent    = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy1"},  32'(busy),      32'd1);
    chk({tag, ".valid1"}, 32'(out_valid), 32'd0);
    chk({tag, ".done1"},  32'(done),      32'd0);
    step();
    chk({tag, ".done2"},  32'(done),      32'd1);
    chk({tag, ".none2"},  32'(none),      32'd1);
    chk({tag, ".valid2"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, ".busy3"},  32'(busy),      32'd0);
    chk({tag, ".done3"},  32'(done),      32'd0);
    chk({tag, ".none3"},  32'(none),      32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    has_dat   = '0;
    nent      = '0;
    out_ready = 1'b1;
    step();
    step();
    chk_idle_outs("reset");
    #2 reset_n = 1'b1;
    step();
    chk_idle_outs("post_reset");

    run_empty("empty");

    run_skip("skip", 1'b0);

    // Backpressure on memory 0, address 1, ready low for four cycles.
    has_dat = 12'b0000_0000_0001;
    nent    = '0;
    set_cnt(0, 6'd3);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_cyc("bp.pick", 1'b0, 4'h0, 6'd0, 1'b0);
    step(); exp_cyc("bp.b0", 1'b1, 4'd1, 6'd0, 1'b0);
    step(); exp_cyc("bp.b1", 1'b1, 4'd1, 6'd1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); exp_cyc("bp.hold", 1'b1, 4'd1, 6'd1, 1'b0);
    end
    step(); exp_cyc("bp.hold_last", 1'b1, 4'd1, 6'd1, 1'b0);
    out_ready = 1'b1;
    step(); exp_cyc("bp.b2", 1'b1, 4'd1, 6'd2, 1'b0);
    step(); exp_cyc("bp.bub", 1'b0, 4'h0, 6'd0, 1'b0);
    step();
    exp_cyc("bp.fin", 1'b0, 4'h0, 6'd0, 1'b1);
    chk("bp.none", 32'(none), 32'd0);
    step();

    run_mismatch("mism");

    // Flush in the middle of memory 0.
    setup_skip();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); exp_cyc("fl.b0", 1'b1, 4'd1, 6'd0, 1'b0);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.sel",   32'(sel),       32'hF);
    chk("fl.busy",  32'(busy),      32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl.no_done",  32'(done),      32'd0);
      chk("fl.no_valid", 32'(out_valid), 32'd0);
    end
    run_mismatch("fl.restart");

    // Asynchronous reset in the middle of an event.
    setup_skip();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); exp_cyc("rs.b0", 1'b1, 4'd1, 6'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_idle_outs("rs.async");
    #1 reset_n = 1'b1;
    step();
    chk_idle_outs("rs.after");
    run_empty("rs.restart");

    // start pulses while busy must not disturb the stream.
    run_skip("ign", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
